// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin selection among four result sources
// with a registered bus word and a flush input that suppresses grants.
module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6,
    parameter int NREQ   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic [NREQ*TAG_W-1:0]  req_tag,
    input  logic [NREQ-1:0]        req_branch,
    input  logic [NREQ-1:0]        req_taken,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   flush,
    output logic [DATA_W-1:0]      cdb_data,
    output logic [TAG_W-1:0]       cdb_tag,
    output logic                   cdb_valid,
    output logic                   cdb_branch,
    output logic                   cdb_branch_taken,
    output logic [1:0]             cdb_grant_id
);

    logic [1:0]        ptr;
    logic [1:0]        grant_idx;
    logic [1:0]        scan_idx;
    logic              grant_any;
    logic [DATA_W-1:0] sel_data;
    logic [TAG_W-1:0]  sel_tag;
    logic              sel_branch;
    logic              sel_taken;

    // Scan from ptr upward with 2-bit wraparound; first valid requester wins.
    always_comb begin
        req_ready = '0;
        grant_any = 1'b0;
        grant_idx = ptr;
        scan_idx  = ptr;
        if (rst && !flush) begin
            for (int i = 0; i < NREQ; i++) begin
                scan_idx = ptr + 2'(i);
                if (!grant_any && req_valid[scan_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = scan_idx;
                end
            end
            if (grant_any) begin
                req_ready[grant_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_data   = '0;
        sel_tag    = '0;
        sel_branch = 1'b0;
        sel_taken  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_idx == 2'(k)) begin
                sel_data   = req_data[k*DATA_W +: DATA_W];
                sel_tag    = req_tag[k*TAG_W +: TAG_W];
                sel_branch = req_branch[k];
                sel_taken  = req_taken[k];
            end
        end
    end

    // Idle cycles keep the last word's payload but clear valid and taken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr              <= 2'd0;
            cdb_valid        <= 1'b0;
            cdb_data         <= '0;
            cdb_tag          <= '0;
            cdb_branch       <= 1'b0;
            cdb_branch_taken <= 1'b0;
            cdb_grant_id     <= 2'd0;
        end else if (grant_any) begin
            ptr              <= grant_idx + 2'd1;
            cdb_valid        <= 1'b1;
            cdb_data         <= sel_data;
            cdb_tag          <= sel_tag;
            cdb_branch       <= sel_branch;
            cdb_branch_taken <= sel_branch & sel_taken;
            cdb_grant_id     <= grant_idx;
        end else begin
            cdb_valid        <= 1'b0;
            cdb_branch_taken <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter: reset, single grant,
// round-robin order, rotation, branch flags and flush suppression.
module tb_cdb_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [23:0]  req_tag;
    logic [3:0]   req_branch;
    logic [3:0]   req_taken;
    logic [3:0]   req_ready;
    logic         flush;
    logic [31:0]  cdb_data;
    logic [5:0]   cdb_tag;
    logic         cdb_valid;
    logic         cdb_branch;
    logic         cdb_branch_taken;
    logic [1:0]   cdb_grant_id;

    int tests_run = 0;
    int tests_failed = 0;

    cdb_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_tag          (req_tag),
        .req_branch       (req_branch),
        .req_taken        (req_taken),
        .req_ready        (req_ready),
        .flush            (flush),
        .cdb_data         (cdb_data),
        .cdb_tag          (cdb_tag),
        .cdb_valid        (cdb_valid),
        .cdb_branch       (cdb_branch),
        .cdb_branch_taken (cdb_branch_taken),
        .cdb_grant_id     (cdb_grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic setReq(input int k, input logic [31:0] d, input logic [5:0] t,
                          input logic br, input logic tk);
        req_data[k*32 +: 32] = d;
        req_tag[k*6 +: 6]    = t;
        req_branch[k]        = br;
        req_taken[k]         = tk;
    endtask

    // Inputs change just after a rising edge; combinational grant is sampled 2ns later.
    task automatic applyStimulus(input logic [3:0] valid, input logic rst_v, input logic flush_v);
        req_valid = valid;
        rst       = rst_v;
        flush     = flush_v;
        #2;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkBus(input string tag, input logic v, input logic [31:0] d,
                            input logic [5:0] t, input logic [1:0] id,
                            input logic br, input logic tk);
        checkOutput({tag, "_valid"}, 64'(cdb_valid), 64'(v));
        checkOutput({tag, "_data"}, 64'(cdb_data), 64'(d));
        checkOutput({tag, "_tag"}, 64'(cdb_tag), 64'(t));
        checkOutput({tag, "_id"}, 64'(cdb_grant_id), 64'(id));
        checkOutput({tag, "_branch"}, 64'(cdb_branch), 64'(br));
        checkOutput({tag, "_taken"}, 64'(cdb_branch_taken), 64'(tk));
    endtask

    initial begin
        logic [1:0] exp_id;
        req_valid = '0; req_data = '0; req_tag = '0; req_branch = '0; req_taken = '0;
        rst = 1'b0; flush = 1'b0;
        for (int k = 0; k < 4; k++) setReq(k, 32'hA000_0000 + 32'(k), 6'(k + 1), 1'b0, 1'b0);
        #1;

        // Reset held for two edges with every requester pending
        for (int c = 0; c < 2; c++) begin
            applyStimulus(4'b1111, 1'b0, 1'b0);
            checkOutput("reset_ready", 64'(req_ready), 64'h0);
            nextCycle();
            checkBus("reset_bus", 1'b0, 32'h0, 6'h0, 2'd0, 1'b0, 1'b0);
        end

        // Release reset: continuous requests give order 0,1,2,3,0,1,2,3
        for (int c = 0; c < 8; c++) begin
            exp_id = 2'(c);
            applyStimulus(4'b1111, 1'b1, 1'b0);
            checkOutput("rr_ready", 64'(req_ready), 64'(4'b0001 << exp_id));
            nextCycle();
            checkBus("rr_bus", 1'b1, 32'hA000_0000 + 32'(exp_id), 6'(exp_id) + 6'd1,
                     exp_id, 1'b0, 1'b0);
        end

        // Single request from unit 1 (ptr=0)
        setReq(1, 32'hDEAD_BEEF, 6'h15, 1'b0, 1'b0);
        applyStimulus(4'b0010, 1'b1, 1'b0);
        checkOutput("single_ready", 64'(req_ready), 64'h2);
        nextCycle();
        checkBus("single_bus", 1'b1, 32'hDEAD_BEEF, 6'h15, 2'd1, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("idle_ready", 64'(req_ready), 64'h0);
        nextCycle();
        checkBus("idle_bus", 1'b0, 32'hDEAD_BEEF, 6'h15, 2'd1, 1'b0, 1'b0);

        // Rotation: ptr=2, grant 2 (ptr->3), then 0101 gives 0, 2, 0
        applyStimulus(4'b0100, 1'b1, 1'b0);
        checkOutput("rot_ready_a", 64'(req_ready), 64'h4);
        nextCycle();
        checkOutput("rot_id_a", 64'(cdb_grant_id), 64'd2);
        applyStimulus(4'b0101, 1'b1, 1'b0);
        checkOutput("rot_ready_b", 64'(req_ready), 64'h1);
        nextCycle();
        checkOutput("rot_id_b", 64'(cdb_grant_id), 64'd0);
        applyStimulus(4'b0101, 1'b1, 1'b0);
        checkOutput("rot_ready_c", 64'(req_ready), 64'h4);
        nextCycle();
        checkOutput("rot_id_c", 64'(cdb_grant_id), 64'd2);
        applyStimulus(4'b0101, 1'b1, 1'b0);
        checkOutput("rot_ready_d", 64'(req_ready), 64'h1);
        nextCycle();
        checkOutput("rot_id_d", 64'(cdb_grant_id), 64'd0);

        // Branch taken from unit 0 (ptr=1), then idle clears taken but holds branch
        setReq(0, 32'h0000_1234, 6'h21, 1'b1, 1'b1);
        applyStimulus(4'b0001, 1'b1, 1'b0);
        checkOutput("br0_ready", 64'(req_ready), 64'h1);
        nextCycle();
        checkBus("br0_bus", 1'b1, 32'h0000_1234, 6'h21, 2'd0, 1'b1, 1'b1);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        nextCycle();
        checkBus("br_idle", 1'b0, 32'h0000_1234, 6'h21, 2'd0, 1'b1, 1'b0);

        // Unit 3: taken without branch must not raise the taken flag
        setReq(3, 32'h0BAD_F00D, 6'h33, 1'b0, 1'b1);
        applyStimulus(4'b1000, 1'b1, 1'b0);
        checkOutput("br3_ready", 64'(req_ready), 64'h8);
        nextCycle();
        checkBus("br3_bus", 1'b1, 32'h0BAD_F00D, 6'h33, 2'd3, 1'b0, 1'b0);

        // Flush for two cycles with unit 3 pending (ptr=0)
        setReq(3, 32'hCAFE_0003, 6'h03, 1'b0, 1'b0);
        setReq(0, 32'hCAFE_0000, 6'h30, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            applyStimulus(4'b1000, 1'b1, 1'b1);
            checkOutput("flush_ready", 64'(req_ready), 64'h0);
            nextCycle();
            checkOutput("flush_valid", 64'(cdb_valid), 64'h0);
        end
        applyStimulus(4'b1000, 1'b1, 1'b0);
        checkOutput("postflush_ready", 64'(req_ready), 64'h8);
        nextCycle();
        checkBus("postflush_bus", 1'b1, 32'hCAFE_0003, 6'h03, 2'd3, 1'b0, 1'b0);
        // ptr wrapped to 0 after grant 3: unit 0 wins over unit 3
        applyStimulus(4'b1001, 1'b1, 1'b0);
        checkOutput("wrap_ready", 64'(req_ready), 64'h1);
        nextCycle();
        checkBus("wrap_bus", 1'b1, 32'hCAFE_0000, 6'h30, 2'd0, 1'b0, 1'b0);

        // Reset arriving while a request is offered: not granted, bus cleared
        applyStimulus(4'b1000, 1'b0, 1'b0);
        checkOutput("midrst_ready", 64'(req_ready), 64'h0);
        nextCycle();
        checkBus("midrst_bus", 1'b0, 32'h0, 6'h0, 2'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
